// File: rtl/req_debounce_latch_if.sv
// Request-conditioning bus: raw requests and clears in, clean request levels out.
interface req_debounce_latch_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0] btn_in;
  logic [N_REQ-1:0] clr_in;
  logic [N_REQ-1:0] d_out;
  logic [N_REQ-1:0] stable_lvl;
  logic [N_REQ-1:0] rise_pulse;

  modport master (
    output btn_in,
    output clr_in,
    input  d_out,
    input  stable_lvl,
    input  rise_pulse
  );

  modport slave (
    input  btn_in,
    input  clr_in,
    output d_out,
    output stable_lvl,
    output rise_pulse
  );
endinterface

// File: rtl/req_debounce_latch.sv
// Synchronise, debounce, edge-detect and optionally latch raw request lines
// ahead of the 3-input priority encoder (bit N_REQ-1 is highest priority).
module req_debounce_latch #(
  parameter int N_REQ     = 3,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3,
  parameter int STICKY    = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  req_debounce_latch_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_REQ-1:0] sync1;
  logic [N_REQ-1:0] sync2;
  logic [N_REQ-1:0] stable;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] rise_set;
  logic [N_REQ-1:0] stable_nxt;
  logic [N_REQ-1:0] pend_nxt;
  logic [CNT_W-1:0] cnt [N_REQ];

  // A bit is accepted on the DB_CYCLES-th consecutive edge its sync2 differs.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise_set   = accept & sync2;
  assign stable_nxt = (stable & ~accept) | (sync2 & accept);
  // Set has priority over clear when both hit the same edge.
  assign pend_nxt   = rise_set | (pend & ~bus.clr_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1          <= '0;
      sync2          <= '0;
      stable         <= '0;
      pend           <= '0;
      bus.rise_pulse <= '0;
      bus.d_out      <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= bus.btn_in;
      sync2 <= sync1;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if ((sync2[i] == stable[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      stable         <= stable_nxt;
      pend           <= pend_nxt;
      bus.rise_pulse <= rise_set;
      bus.d_out      <= (STICKY != 0) ? pend_nxt : stable_nxt;
    end
  end

  assign bus.stable_lvl = stable;

endmodule

// File: tb/tb_req_debounce_latch.sv
// Bench for req_debounce_latch: sticky and level-following instances share stimulus.
module tb_req_debounce_latch;

  localparam int N  = 3;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn;
  logic [N-1:0] clr;

  int checks   = 0;
  int failures = 0;

  req_debounce_latch_if #(.N_REQ(N)) bus_s ();
  req_debounce_latch_if #(.N_REQ(N)) bus_l ();

  assign bus_s.btn_in = btn;
  assign bus_s.clr_in = clr;
  assign bus_l.btn_in = btn;
  assign bus_l.clr_in = clr;

  req_debounce_latch #(.N_REQ(N), .DB_CYCLES(DB), .CNT_W(3), .STICKY(1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  req_debounce_latch #(.N_REQ(N), .DB_CYCLES(DB), .CNT_W(3), .STICKY(0)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] d_s;
    logic [N-1:0] d_l;
    logic [N-1:0] stab;
    logic [N-1:0] rise;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: acceptance means the last DB sync2 samples since reset all differ from stable.
  logic [N-1:0] m_s1, m_s2, m_stab, m_pend, m_rise;
  logic [31:0]  m_win [N];
  int           m_since;

  task automatic model_edge();
    logic acc;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_pend = '0; m_rise = '0;
      m_since = 0;
      for (int i = 0; i < N; i++) m_win[i] = '0;
    end else begin
      if (m_since < DB) m_since++;
      for (int i = 0; i < N; i++) begin
        m_win[i] = {m_win[i][30:0], m_s2[i]};
        acc = (m_since >= DB);
        for (int j = 0; j < DB; j++) begin
          if (m_win[i][j] == m_stab[i]) acc = 1'b0;
        end
        m_rise[i] = acc & m_s2[i];
        if (acc) m_stab[i] = m_s2[i];
      end
      m_pend = m_rise | (m_pend & ~clr);
      m_s2   = m_s1;
      m_s1   = btn;
    end
    sb_q.push_back('{d_s: m_pend, d_l: m_stab, stab: m_stab, rise: m_rise});
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({bus_s.d_out, bus_l.d_out, bus_s.stable_lvl, bus_s.rise_pulse, bus_l.stable_lvl, bus_l.rise_pulse}
          !== {e.d_s, e.d_l, e.stab, e.rise, e.stab, e.rise}) begin
        failures++;
        $display("FAIL scoreboard t=%0t got d_s=%b d_l=%b stab=%b/%b rise=%b/%b want d_s=%b d_l=%b stab=%b rise=%b",
                 $time, bus_s.d_out, bus_l.d_out, bus_s.stable_lvl, bus_l.stable_lvl,
                 bus_s.rise_pulse, bus_l.rise_pulse, e.d_s, e.d_l, e.stab, e.rise);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; btn = '0; clr = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_s.d_out, bus_s.stable_lvl, bus_s.rise_pulse} !== 9'b0) begin
      failures++;
      $display("FAIL reset_state got d=%b stab=%b rise=%b want all 0",
               bus_s.d_out, bus_s.stable_lvl, bus_s.rise_pulse);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_s.d_out, bus_s.stable_lvl, bus_s.rise_pulse} !== 9'b0) begin
        failures++;
        $display("FAIL idle_zero k=%0d got d=%b stab=%b rise=%b want all 0",
                 k, bus_s.d_out, bus_s.stable_lvl, bus_s.rise_pulse);
      end
    end
  endtask

  task automatic test_glitch();
    btn = 3'b010;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 3) btn = '0;
      checks++;
      if ({bus_s.stable_lvl[1], bus_s.rise_pulse[1], bus_s.d_out[1]} !== 3'b000) begin
        failures++;
        $display("FAIL glitch_reject k=%0d got stab=%b rise=%b d=%b want 0 0 0",
                 k, bus_s.stable_lvl[1], bus_s.rise_pulse[1], bus_s.d_out[1]);
      end
    end
  endtask

  task automatic test_accept();
    logic [N-1:0] want_stab, want_rise, want_d;
    btn = 3'b010;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      want_stab = (k >= 6) ? 3'b010 : 3'b000;
      want_rise = (k == 6) ? 3'b010 : 3'b000;
      want_d    = (k >= 6) ? 3'b010 : 3'b000;
      checks++;
      if ({bus_s.stable_lvl, bus_s.rise_pulse, bus_s.d_out} !== {want_stab, want_rise, want_d}) begin
        failures++;
        $display("FAIL accept_rise k=%0d got stab=%b rise=%b d=%b want stab=%b rise=%b d=%b",
                 k, bus_s.stable_lvl, bus_s.rise_pulse, bus_s.d_out, want_stab, want_rise, want_d);
      end
    end
    btn = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      want_stab = (k >= 6) ? 3'b000 : 3'b010;
      checks++;
      if ({bus_s.stable_lvl, bus_s.rise_pulse, bus_s.d_out} !== {want_stab, 3'b000, 3'b010}) begin
        failures++;
        $display("FAIL accept_fall k=%0d got stab=%b rise=%b d=%b want stab=%b rise=000 d=010",
                 k, bus_s.stable_lvl, bus_s.rise_pulse, bus_s.d_out, want_stab);
      end
    end
  endtask

  task automatic test_clear();
    clr = 3'b010;
    @(negedge clk);
    clr = '0;
    checks++;
    if (bus_s.d_out !== 3'b000) begin
      failures++;
      $display("FAIL clear_pend got d=%b want 000", bus_s.d_out);
    end
    btn = 3'b010;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) clr = 3'b010;
    end
    clr = '0;
    checks++;
    if ({bus_s.d_out, bus_s.rise_pulse} !== {3'b010, 3'b010}) begin
      failures++;
      $display("FAIL set_wins got d=%b rise=%b want d=010 rise=010", bus_s.d_out, bus_s.rise_pulse);
    end
    @(negedge clk);
    checks++;
    if (bus_s.d_out !== 3'b010) begin
      failures++;
      $display("FAIL set_wins_hold got d=%b want 010", bus_s.d_out);
    end
    btn = '0;
    repeat (8) @(negedge clk);
    clr = 3'b111;
    @(negedge clk);
    clr = '0;
    checks++;
    if ({bus_s.d_out, bus_s.stable_lvl} !== 6'b0) begin
      failures++;
      $display("FAIL clear_tidy got d=%b stab=%b want 000 000", bus_s.d_out, bus_s.stable_lvl);
    end
  endtask

  task automatic test_multi_reset();
    logic [N-1:0] want_stab, want_rise;
    btn = 3'b101;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      want_stab = (k >= 6) ? 3'b101 : 3'b000;
      want_rise = (k == 6) ? 3'b101 : 3'b000;
      checks++;
      if ({bus_s.d_out, bus_s.stable_lvl, bus_s.rise_pulse} !== {want_stab, want_stab, want_rise}) begin
        failures++;
        $display("FAIL multi_rise k=%0d got d=%b stab=%b rise=%b want d=%b stab=%b rise=%b",
                 k, bus_s.d_out, bus_s.stable_lvl, bus_s.rise_pulse, want_stab, want_stab, want_rise);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_s.d_out, bus_s.stable_lvl, bus_s.rise_pulse, bus_l.d_out} !== 12'b0) begin
      failures++;
      $display("FAIL async_reset got d=%b stab=%b rise=%b d_l=%b want all 0",
               bus_s.d_out, bus_s.stable_lvl, bus_s.rise_pulse, bus_l.d_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      want_stab = (k >= 6) ? 3'b101 : 3'b000;
      want_rise = (k == 6) ? 3'b101 : 3'b000;
      checks++;
      if ({bus_s.stable_lvl, bus_s.rise_pulse} !== {want_stab, want_rise}) begin
        failures++;
        $display("FAIL held_thru_reset k=%0d got stab=%b rise=%b want stab=%b rise=%b",
                 k, bus_s.stable_lvl, bus_s.rise_pulse, want_stab, want_rise);
      end
    end
    btn = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_nonsticky();
    int rise_k = -1;
    int fall_k = -1;
    btn = 3'b100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 8) btn = '0;
      if (rise_k < 0 && bus_l.d_out[2] === 1'b1) rise_k = k;
      if (rise_k >= 0 && fall_k < 0 && bus_l.d_out[2] === 1'b0) fall_k = k;
    end
    checks++;
    if (rise_k != 6) begin
      failures++;
      $display("FAIL level_rise_edge got %0d want 6", rise_k);
    end
    checks++;
    if (fall_k != 14) begin
      failures++;
      $display("FAIL level_fall_edge got %0d want 14", fall_k);
    end
    checks++;
    if (bus_s.d_out[2] !== 1'b1) begin
      failures++;
      $display("FAIL sticky_vs_level got d_s[2]=%b want 1", bus_s.d_out[2]);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_accept();
    test_clear();
    test_multi_reset();
    test_nonsticky();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
